stepdown_gate_sequencer: RTL and testbench

- Synchronous break-before-make sequencer for the stepdown power stage. It converts a PWM request into mutually exclusive high-side and low-side gate enables, with a programmable dead time between them.
- Each dead-time interval drives the fixed 1 ns delay cell (dly_i) and requires the cell's echo (dly_o) before it commits the next gate. A missing echo latches a fault.
- Sits in the stepdown core-state logic, between the PWM modulator and the gate drivers.

---
 rtl/stepdown_gate_sequencer_if.sv | 39 +++
 rtl/stepdown_gate_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_stepdown_gate_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stepdown_gate_sequencer_if.sv
// Signal bundle between the PWM modulator / delay cell and the stepdown gate sequencer.
// sw_cnt is present only when STEPDOWN_SWCNT_EN is defined.
interface stepdown_gate_sequencer_if #(
  parameter int DT_W = 4
);
  logic            en;
  logic            pwm;
  logic            fault;
  logic            flt_clr;
  logic [DT_W-1:0] dt_cfg;
  logic            dly_o;
  logic            dly_i;
  logic            hs_on;
  logic            ls_on;
  logic [2:0]      state;
  logic            flt;
  logic [1:0]      flt_src;
`ifdef STEPDOWN_SWCNT_EN
  logic [15:0]     sw_cnt;

  modport master (
    output en, pwm, fault, flt_clr, dt_cfg, dly_o,
    input  dly_i, hs_on, ls_on, state, flt, flt_src, sw_cnt
  );
  modport slave (
    input  en, pwm, fault, flt_clr, dt_cfg, dly_o,
    output dly_i, hs_on, ls_on, state, flt, flt_src, sw_cnt
  );
`else
  modport master (
    output en, pwm, fault, flt_clr, dt_cfg, dly_o,
    input  dly_i, hs_on, ls_on, state, flt, flt_src
  );
  modport slave (
    input  en, pwm, fault, flt_clr, dt_cfg, dly_o,
    output dly_i, hs_on, ls_on, state, flt, flt_src
  );
`endif
endinterface

// File: rtl/stepdown_gate_sequencer.sv
// Break-before-make gate sequencer: PWM request -> exclusive HS/LS enables with echoed dead time.
// Optional switch counter output sw_cnt enabled by defining STEPDOWN_SWCNT_EN.
//
// state    | meaning
// OFF   0  | converter idle, both gates off
// LS    1  | low-side gate on
// DT_LH 2  | dead time LS->HS, delay cell driven
// HS    3  | high-side gate on
// DT_HL 4  | dead time HS->LS, delay cell driven
// FAULT 5  | latched fault, gates off until cleared
module stepdown_gate_sequencer #(
  parameter int DT_W   = 4,
  parameter int MIN_ON = 2,
  parameter int TMO    = 20
) (
  input  logic CELCLK,
  input  logic CELRST,
  input  logic CELV,
  input  logic CELG,
  input  logic CELSUB,
  stepdown_gate_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_LS    = 3'd1,
    ST_DT_LH = 3'd2,
    ST_HS    = 3'd3,
    ST_DT_HL = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam int ON_W  = (MIN_ON < 1) ? 1 : $clog2(MIN_ON + 1);
  localparam int TMO_W = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [ON_W-1:0]  MIN_ON_C = ON_W'(MIN_ON);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
  localparam logic [DT_W-1:0]  DT_ONE   = DT_W'(1);

  // Supply/substrate pins are physical connections only.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, CELSUB};

  state_e            state_q, state_d;
  logic [ON_W-1:0]   on_cnt_q, on_cnt_d;
  logic [DT_W-1:0]   dt_cnt_q, dt_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              echo_q, echo_d;
  logic              flt_q, flt_d;
  logic [1:0]        flt_src_q, flt_src_d;
  logic              hs_on_q, hs_on_d;
  logic              ls_on_q, ls_on_d;
  logic              dly_i_q, dly_i_d;

  logic in_dt, in_on, dt_entry, on_entry, dt_exit, tmo_hit;

  assign in_dt    = (state_q == ST_DT_LH) || (state_q == ST_DT_HL);
  assign in_on    = (state_q == ST_LS) || (state_q == ST_HS);
  assign dt_exit  = (dt_cnt_q <= DT_ONE) && (echo_q || bus.dly_o);
  assign tmo_hit  = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    flt_d     = flt_q;
    flt_src_d = flt_src_q;
    if (bus.fault && (state_q != ST_FAULT)) begin
      state_d   = ST_FAULT;
      flt_d     = 1'b1;
      flt_src_d = 2'b01;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (bus.en && !bus.pwm) state_d = ST_LS;
        end
        ST_LS: begin
          if (!bus.en) state_d = ST_OFF;
          else if (bus.pwm && (on_cnt_q >= MIN_ON_C)) state_d = ST_DT_LH;
        end
        ST_HS: begin
          if (!bus.en) state_d = ST_OFF;
          else if (!bus.pwm && (on_cnt_q >= MIN_ON_C)) state_d = ST_DT_HL;
        end
        ST_DT_LH, ST_DT_HL: begin
          if (!bus.en) begin
            state_d = ST_OFF;
          end else if (dt_exit) begin
            state_d = (state_q == ST_DT_LH) ? ST_HS : ST_LS;
          end else if (tmo_hit) begin
            state_d   = ST_FAULT;
            flt_d     = 1'b1;
            flt_src_d = 2'b10;
          end
        end
        ST_FAULT: begin
          if (bus.flt_clr && !bus.fault) begin
            state_d   = ST_OFF;
            flt_d     = 1'b0;
            flt_src_d = 2'b00;
          end
        end
        default: begin
          state_d   = ST_FAULT;
          flt_d     = 1'b1;
          flt_src_d = 2'b10;
        end
      endcase
    end
  end

  assign dt_entry = ((state_d == ST_DT_LH) || (state_d == ST_DT_HL)) && (state_d != state_q);
  assign on_entry = ((state_d == ST_LS) || (state_d == ST_HS)) && (state_d != state_q);

  // Dead-time bookkeeping: dt_cfg is captured only on entry, later changes are ignored.
  always_comb begin
    on_cnt_d  = on_cnt_q;
    dt_cnt_d  = dt_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    echo_d    = echo_q;
    if (on_entry) begin
      on_cnt_d = '0;
    end else if (in_on && (on_cnt_q < MIN_ON_C)) begin
      on_cnt_d = on_cnt_q + 1'b1;
    end
    if (dt_entry) begin
      dt_cnt_d  = (bus.dt_cfg == '0) ? DT_ONE : bus.dt_cfg;
      tmo_cnt_d = '0;
      echo_d    = 1'b0;
    end else if (in_dt) begin
      dt_cnt_d  = (dt_cnt_q == '0) ? dt_cnt_q : dt_cnt_q - 1'b1;
      tmo_cnt_d = tmo_hit ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      echo_d    = echo_q | bus.dly_o;
    end
  end

  always_comb begin
    hs_on_d = (state_d == ST_HS);
    ls_on_d = (state_d == ST_LS);
    dly_i_d = (state_d == ST_DT_LH) || (state_d == ST_DT_HL);
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q   <= ST_OFF;
      on_cnt_q  <= '0;
      dt_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      echo_q    <= 1'b0;
      flt_q     <= 1'b0;
      flt_src_q <= 2'b00;
      hs_on_q   <= 1'b0;
      ls_on_q   <= 1'b0;
      dly_i_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      dt_cnt_q  <= dt_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      echo_q    <= echo_d;
      flt_q     <= flt_d;
      flt_src_q <= flt_src_d;
      hs_on_q   <= hs_on_d;
      ls_on_q   <= ls_on_d;
      dly_i_q   <= dly_i_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.hs_on   = hs_on_q;
  assign bus.ls_on   = ls_on_q;
  assign bus.dly_i   = dly_i_q;
  assign bus.flt     = flt_q;
  assign bus.flt_src = flt_src_q;

`ifdef STEPDOWN_SWCNT_EN
  logic [15:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if ((state_q == ST_FAULT) && (state_d == ST_OFF)) begin
      sw_cnt_d = '0;
    end else if ((state_q == ST_DT_LH) && (state_d == ST_HS) && (sw_cnt_q != 16'hFFFF)) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) sw_cnt_q <= '0;
    else        sw_cnt_q <= sw_cnt_d;
  end

  assign bus.sw_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_stepdown_gate_sequencer.sv
// Directed bench for stepdown_gate_sequencer: hand-derived state/output expectations per edge.
module tb_stepdown_gate_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tie_echo = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  stepdown_gate_sequencer_if #(.DT_W(4)) sig ();

  stepdown_gate_sequencer #(.DT_W(4), .MIN_ON(2), .TMO(20)) dut (
    .CELCLK (clk),
    .CELRST (rst),
    .CELV   (1'b1),
    .CELG   (1'b0),
    .CELSUB (1'b0),
    .bus    (sig)
  );

  always #5 clk = ~clk;

  always_comb sig.dly_o = tie_echo ? sig.dly_i : 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic hs,
                         input logic ls, input logic di);
    chk({tag, "_state"}, 16'(sig.state), 16'(st));
    chk({tag, "_hs"},    16'(sig.hs_on), 16'(hs));
    chk({tag, "_ls"},    16'(sig.ls_on), 16'(ls));
    chk({tag, "_dly"},   16'(sig.dly_i), 16'(di));
  endtask

  initial begin
    sig.en = 1'b0; sig.pwm = 1'b0; sig.fault = 1'b0; sig.flt_clr = 1'b0; sig.dt_cfg = 4'd0;
    step(2);
    chk_out("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_flt", 16'(sig.flt), 16'd0);
    chk("rst_src", 16'(sig.flt_src), 16'd0);
    rst = 1'b0;

    // Normal LS -> HS -> LS with dt_cfg=3 and echo looped back.
    tie_echo = 1'b1; sig.dt_cfg = 4'd3; sig.en = 1'b1;
    step(1);
    chk_out("ls_entry", 3'd1, 1'b0, 1'b1, 1'b0);
    step(4);
    sig.pwm = 1'b1;
    step(1);
    chk_out("dtlh_1", 3'd2, 1'b0, 1'b0, 1'b1);
    step(2);
    chk_out("dtlh_3", 3'd2, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_out("hs_on", 3'd3, 1'b1, 1'b0, 1'b0);
    step(4);
    sig.pwm = 1'b0;
    step(1);
    chk_out("dthl_1", 3'd4, 1'b0, 1'b0, 1'b1);
    step(2);
    chk("dthl_3_state", 16'(sig.state), 16'd4);
    step(1);
    chk_out("ls_back", 3'd1, 1'b0, 1'b1, 1'b0);

    // dt_cfg=0 gives one dead cycle; pwm one cycle after LS entry waits for MIN_ON.
    sig.dt_cfg = 4'd0;
    step(1);
    sig.pwm = 1'b1;
    step(1);
    chk_out("minon_hold", 3'd1, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_out("dt0_dead", 3'd2, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_out("dt0_hs", 3'd3, 1'b1, 1'b0, 1'b0);

    // en drop during DT_HL.
    sig.dt_cfg = 4'd5;
    step(3);
    sig.pwm = 1'b0;
    step(1);
    chk("dthl_en_state", 16'(sig.state), 16'd4);
    sig.en = 1'b0;
    step(1);
    chk_out("en_drop", 3'd0, 1'b0, 1'b0, 1'b0);

    // pwm=1 in OFF is ignored.
    sig.en = 1'b1; sig.pwm = 1'b1;
    step(2);
    chk("off_pwm_hi", 16'(sig.state), 16'd0);

    // Echo timeout: no echo in DT_LH -> FAULT after 20 cycles.
    sig.pwm = 1'b0;
    step(1);
    chk("tmo_ls", 16'(sig.state), 16'd1);
    tie_echo = 1'b0; sig.dt_cfg = 4'd3;
    step(2);
    sig.pwm = 1'b1;
    step(1);
    chk("tmo_dt_entry", 16'(sig.state), 16'd2);
    step(19);
    chk("tmo_still_dt", 16'(sig.state), 16'd2);
    step(1);
    chk_out("tmo_fault", 3'd5, 1'b0, 1'b0, 1'b0);
    chk("tmo_flt", 16'(sig.flt), 16'd1);
    chk("tmo_src", 16'(sig.flt_src), 16'd2);
    sig.pwm = 1'b0; sig.flt_clr = 1'b1;
    step(1);
    chk("clr_state", 16'(sig.state), 16'd0);
    chk("clr_flt", 16'(sig.flt), 16'd0);
    chk("clr_src", 16'(sig.flt_src), 16'd0);
    sig.flt_clr = 1'b0;
`ifdef STEPDOWN_SWCNT_EN
    chk("sw_after_clr", sig.sw_cnt, 16'd0);
`endif

    // External fault in HS; clear while fault held is ignored.
    tie_echo = 1'b1; sig.dt_cfg = 4'd2;
    step(1);
    chk("xf_ls", 16'(sig.state), 16'd1);
    step(2);
    sig.pwm = 1'b1;
    step(1);
    chk("xf_dt", 16'(sig.state), 16'd2);
    step(2);
    chk_out("xf_hs", 3'd3, 1'b1, 1'b0, 1'b0);
    sig.fault = 1'b1;
    step(1);
    chk_out("xf_fault", 3'd5, 1'b0, 1'b0, 1'b0);
    chk("xf_flt", 16'(sig.flt), 16'd1);
    chk("xf_src", 16'(sig.flt_src), 16'd1);
    sig.flt_clr = 1'b1;
    step(2);
    chk("xf_clr_ignored", 16'(sig.state), 16'd5);
    chk("xf_src_held", 16'(sig.flt_src), 16'd1);
    sig.fault = 1'b0;
    step(1);
    chk("xf_cleared", 16'(sig.state), 16'd0);
    chk("xf_flt_clr", 16'(sig.flt), 16'd0);
    sig.flt_clr = 1'b0;

`ifdef STEPDOWN_SWCNT_EN
    // Three full LS->HS->LS cycles.
    sig.dt_cfg = 4'd0; sig.pwm = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      step(3);
      sig.pwm = 1'b1;
      step(3);
      sig.pwm = 1'b0;
      step(3);
    end
    chk("sw_cnt_3", sig.sw_cnt, 16'd3);
    sig.fault = 1'b1;
    step(1);
    sig.fault = 1'b0; sig.flt_clr = 1'b1;
    step(1);
    sig.flt_clr = 1'b0;
    chk("sw_cnt_clr", sig.sw_cnt, 16'd0);
`endif

    // Reset mid-operation forces gates off on the next edge.
    sig.pwm = 1'b0;
    step(1);
    chk("mid_ls", 16'(sig.state), 16'd1);
    rst = 1'b1;
    step(1);
    chk_out("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && sig.hs_on && sig.ls_on) begin
      n_chk++;
      n_err++;
      $display("FAIL gate_overlap got=hs1_ls1 exp=exclusive");
    end
  end
endmodule
